fetch_stage: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC register, issues word reads to instruction memory through a request/valid handshake that tolerates wait states, and drives the IF/ID pipeline register consumed by decode and the hazard unit. It obeys StallF/StallD/FlushD from the hazard unit and redirects on PCSrcE from execute. A redirect that arrives while a memory read is outstanding is held until that read completes.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC register, wait-state tolerant imem reads, IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_pcsrc_e,
    input  logic [31:0] i_pc_target_e,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic        o_fetch_busy,
    output logic        o_misaligned_target
);
    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_saved_target;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic        r_if_valid;

    logic        w_req;
    logic        w_complete;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_req      = (r_state != S_BOOT);
    assign w_complete = w_req & i_imem_valid;
    assign w_target   = {i_pc_target_e[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    assign o_imem_req          = w_req;
    assign o_imem_addr         = r_pc;
    assign o_fetch_busy        = ((r_state == S_FETCH) & ~i_imem_valid) | (r_state == S_DISCARD);
    assign o_misaligned_target = i_pcsrc_e & (i_pc_target_e[1:0] != 2'b00);
    assign o_if_id_instr       = r_instr;
    assign o_if_id_pc          = r_if_pc;
    assign o_if_id_pc_plus4    = r_if_pc_plus4;
    assign o_if_id_valid       = r_if_valid;

    // A redirect seen mid-read parks in DISCARD so the address stays stable until the old read retires.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_saved_target <= 32'h0;
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_FETCH;
                S_FETCH: begin
                    if (i_pcsrc_e) begin
                        if (w_complete) begin
                            r_pc <= w_target;
                        end else begin
                            r_saved_target <= w_target;
                            r_state        <= S_DISCARD;
                        end
                    end else if (!i_stall_f && w_complete) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                S_DISCARD: begin
                    if (i_pcsrc_e) begin
                        r_saved_target <= w_target;
                    end
                    if (w_complete) begin
                        r_pc    <= i_pcsrc_e ? w_target : r_saved_target;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    // Bubbles keep the old pc/pc_plus4; only instr and valid change.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr       <= NOP_INSTR;
            r_if_pc       <= 32'h0;
            r_if_pc_plus4 <= 32'h0;
            r_if_valid    <= 1'b0;
        end else if (i_flush_d) begin
            r_instr    <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (i_stall_d) begin
            r_instr    <= r_instr;
        end else if ((r_state == S_FETCH) && w_complete && !i_pcsrc_e) begin
            r_instr       <= i_imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_valid    <= 1'b1;
        end else begin
            r_instr    <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end
    end
endmodule
